stream_sink: RTL
================

Name: stream_sink

Overview:
- StreamBus slave: consumer end of the stream produced by the 1 Hz digit source in the UART experiments.
- Accepts beats on valid/ready and applies programmable backpressure by holding ready low for a fixed number of cycles after each accept.
- Checks that received data follows an incrementing modulo-N sequence.
- Exposes the last value, a beat count and an error count for LEDs or seven-segment display.

Parameters:
- N, 10, modulus of the expected data sequence (valid values 0..N-1)
- HOLD, 0, cycles ready stays low after each accepted beat (0 = ready always high)
- DW, 8, data width; must equal the StreamBus data width

Ports:
- bus.clk  input  1  the single clock, taken from the interface
- bus.rst  input  1  asynchronous, active-high reset, taken from the interface
- bus.valid  input  1  beat offered by master
- bus.data  input  DW  beat payload
- bus.ready  output  1  sink can accept this cycle
- last_data  output  DW  payload of most recent accepted beat
- beat_cnt  output  16  accepted beats since reset
- err_cnt  output  8  sequence errors since reset
- err  output  1  one-cycle pulse on a sequence error
- synced  output  1  high once the first beat has been accepted

Behaviour:
- Interface and reset:
  - Block connects as StreamBus.Slave.
  - bus.rst is asynchronous and active-high; every register clears immediately on assertion, independent of bus.clk.
- Reset values:
  - State = ACCEPT, so bus.ready=1.
  - last_data=0, beat_cnt=0, err_cnt=0, err=0, synced=0.
  - Hold counter = 0; expected value = 0.
- Handshake:
  - A beat is accepted on a rising edge where bus.valid & bus.ready.
  - No combinational path from bus.valid to bus.ready; ready is a function of state only.
- State machine:
  - ACCEPT: ready=1. On accept with HOLD>0, load hold counter with HOLD-1 and go to STALL. On accept with HOLD=0, stay in ACCEPT.
  - STALL: ready=0. Decrement hold counter each cycle; return to ACCEPT on the cycle after it reads 0.
  - Result: exactly HOLD ready-low cycles between accepts.
  - bus.valid during STALL is ignored; the master must hold data/valid per StreamBus rules.
- On every accept, all updates become visible the next cycle:
  - last_data <= bus.data.
  - beat_cnt <= beat_cnt+1, wrapping from 65535 to 0.
  - If synced=0: set synced=1, no compare, err=0.
  - Else if bus.data != expected: err=1 for one cycle, err_cnt+1 saturating at 255.
  - expected <= (bus.data==N-1) ? 0 : bus.data+1. This resyncs on the received value, so one bad beat yields exactly one error.
  - A received value >= N always counts as an error (once synced); expected then becomes 0.
- Latency: accepted beat reflected on outputs 1 cycle after the accept edge.
- Throughput: one beat per HOLD+1 cycles, maximum.
- Mid-operation reset: reset asserted in STALL or mid-sequence returns to the reset values. Sync is re-acquired on the next beat and produces no error.
- Arithmetic: expected compare is zero-extended to DW bits; counters are unsigned.

Decomposition:
- Shared package stream_pkg holds:
  - typedef enum logic {ACCEPT, STALL} sink_state_t
  - localparam BEAT_CNT_W=16 and ERR_CNT_W=8
- Natural sub-module: reuse the existing counter module (N=HOLD, ce=stall-active) for the hold timer when HOLD>0.
- Sequence checker stays inline.

Test Plan:
- Reset, HOLD=0: feed 0,1,...,9,0,1 back-to-back -> ready constantly 1, beat_cnt=12, err_cnt=0, last_data=1, err never pulses.
- HOLD=3: valid held high with incrementing data -> ready low exactly 3 cycles after each accept, one accept every 4 cycles, no errors.
- Sequence 3,4,7,8,9,0 (first beat 3) -> synced after first beat, a single err pulse on beat 7, err_cnt=1, no error on 8/9/0.
- Out-of-range data 12 mid-stream, then 0 -> err_cnt+1 on 12, no error on following 0.
- Assert rst asynchronously in STALL (HOLD=5) with err_cnt=2 -> all outputs zero without a clock edge, ready=1; next beat 6 gives no error.
- Connect to the 1 Hz source with F=20 in simulation, HOLD=2 -> last_data cycles 0..9, err_cnt=0, beat_cnt increments once per source period.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared types and widths for the StreamBus sink.
package stream_pkg;

  typedef enum logic {ACCEPT, STALL} sink_state_t;

  localparam int BEAT_CNT_W = 16;
  localparam int ERR_CNT_W  = 8;

endpackage

// File: rtl/stream_bus_if.sv
// StreamBus valid/ready link carrying clock and reset alongside the payload.
interface StreamBus #(
  parameter int DW = 8
) (
  input logic clk,
  input logic rst
);

  logic          valid;
  logic          ready;
  logic [DW-1:0] data;

  modport Master (input clk, input rst, input ready, output valid, output data);
  modport Slave  (input clk, input rst, input valid, input data, output ready);

endinterface

// File: rtl/stream_sink_counter.sv
// Modulo-N counter with clock enable; tc flags the enabled cycle that wraps to zero.
module stream_sink_counter #(
  parameter int N = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  output logic tc
);

  localparam int W = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    tc      = ce && (count_q == LAST);
    count_d = count_q;
    if (ce) begin
      count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/stream_sink.sv
// StreamBus consumer with fixed post-accept backpressure and a modulo-N sequence checker.
module stream_sink
  import stream_pkg::*;
#(
  parameter int N    = 10,
  parameter int HOLD = 0,
  parameter int DW   = 8
) (
  StreamBus.Slave                 bus,
  output logic [DW-1:0]           last_data,
  output logic [BEAT_CNT_W-1:0]   beat_cnt,
  output logic [ERR_CNT_W-1:0]    err_cnt,
  output logic                    err,
  output logic                    synced
);

  localparam logic [DW-1:0] LAST_VAL = DW'(N - 1);

  sink_state_t state_q, state_d;
  logic        ready_q, ready_d;
  logic        accept;
  logic        hold_done;

  logic [DW-1:0]         last_data_q, last_data_d;
  logic [DW-1:0]         expected_q, expected_d;
  logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic                  err_q, err_d;
  logic                  synced_q, synced_d;

  // ready comes straight from a flop, so valid never reaches it combinationally
  assign accept    = bus.valid && ready_q;
  assign bus.ready = ready_q;

  generate
    if (HOLD > 0) begin : g_hold
      stream_sink_counter #(.N(HOLD)) u_hold (
        .clk (bus.clk),
        .rst (bus.rst),
        .ce  (state_q == STALL),
        .tc  (hold_done)
      );
    end else begin : g_no_hold
      assign hold_done = 1'b1;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCEPT:  if (accept && (HOLD > 0)) state_d = STALL;
      STALL:   if (hold_done) state_d = ACCEPT;
      default: state_d = ACCEPT;
    endcase
    ready_d = (state_d == ACCEPT);
  end

  always_ff @(posedge bus.clk or posedge bus.rst) begin
    if (bus.rst) begin
      state_q <= ACCEPT;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
    end
  end

  // Expected value follows whatever was received, so one bad beat costs one error
  always_comb begin
    last_data_d = last_data_q;
    expected_d  = expected_q;
    beat_cnt_d  = beat_cnt_q;
    err_cnt_d   = err_cnt_q;
    err_d       = 1'b0;
    synced_d    = synced_q;
    if (accept) begin
      last_data_d = bus.data;
      beat_cnt_d  = beat_cnt_q + 1'b1;
      expected_d  = (bus.data >= LAST_VAL) ? '0 : bus.data + 1'b1;
      if (!synced_q) begin
        synced_d = 1'b1;
      end else if (bus.data != expected_q) begin
        err_d = 1'b1;
        if (err_cnt_q != '1) begin
          err_cnt_d = err_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge bus.clk or posedge bus.rst) begin
    if (bus.rst) begin
      last_data_q <= '0;
      expected_q  <= '0;
      beat_cnt_q  <= '0;
      err_cnt_q   <= '0;
      err_q       <= 1'b0;
      synced_q    <= 1'b0;
    end else begin
      last_data_q <= last_data_d;
      expected_q  <= expected_d;
      beat_cnt_q  <= beat_cnt_d;
      err_cnt_q   <= err_cnt_d;
      err_q       <= err_d;
      synced_q    <= synced_d;
    end
  end

  assign last_data = last_data_q;
  assign beat_cnt  = beat_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign err       = err_q;
  assign synced    = synced_q;

endmodule
